lvcontrol_fsm: RTL and testbench

Multi-cycle control unit that sequences the 64-bit LEGv8-style datapath: register file, ALU, shared data bus, program counter and RAM. Each instruction is fetched from RAM into the datapath's instruction register, then executed. The block emits the full control word every cycle, as a function of FSM state, the latched instruction and the live ALU status. It sits beside the datapath at top level and is the only driver of its control inputs.

---
 rtl/lvcontrol_fsm_if.sv | 36 +++
 rtl/lvcontrol_fsm.sv | 189 ++++++++++++++++++
 tb/tb_lvcontrol_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lvcontrol_fsm_if.sv
// Control/status bundle between lvcontrol_fsm (master) and the LEGv8-style datapath (slave).
interface lvcontrol_fsm_if;
  logic [31:0] IR;
  logic [3:0]  status;
  logic        mem_ready;

  logic        IL;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [4:0]  DA;
  logic        W;
  logic [4:0]  FS;
  logic        C0;
  logic [63:0] K;
  logic        B_sel;
  logic        EN_B;
  logic        EN_ALU;
  logic        OUT_EN;
  logic        WR_EN;
  logic        EN_ADDR_PC;
  logic [1:0]  PS;
  logic        EN_PC;
  logic        halted;

  modport master (
    input  IR, status, mem_ready,
    output IL, SA, SB, DA, W, FS, C0, K, B_sel, EN_B, EN_ALU, OUT_EN,
           WR_EN, EN_ADDR_PC, PS, EN_PC, halted
  );

  modport slave (
    output IR, status, mem_ready,
    input  IL, SA, SB, DA, W, FS, C0, K, B_sel, EN_B, EN_ALU, OUT_EN,
           WR_EN, EN_ADDR_PC, PS, EN_PC, halted
  );
endinterface

// File: rtl/lvcontrol_fsm.sv
// Multi-cycle fetch/execute control unit for the LEGv8-style datapath.
// Define LVCONTROL_BCOND_EN to add B.cond decode and its 4-bit flag register.
module lvcontrol_fsm #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic            clock,
  input  logic            reset,
  lvcontrol_fsm_if.master bus
);
  typedef enum logic [1:0] {S_RST, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      state;
  state_t      state_next;
  logic [10:0] opcode;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [63:0] k_imm12;
  logic [63:0] k_dt;
  logic [63:0] k_cb;
  logic [63:0] k_b;
  logic        illegal;

  assign opcode  = bus.IR[31:21];
  assign rd      = bus.IR[4:0];
  assign rn      = bus.IR[9:5];
  assign rm      = bus.IR[20:16];
  assign k_imm12 = 64'(bus.IR[21:10]);
  assign k_dt    = {{55{bus.IR[20]}}, bus.IR[20:12]};
  // Branch offsets are pre-biased by PC_STEP because PC already advanced during fetch.
  assign k_cb    = {{43{bus.IR[23]}}, bus.IR[23:5], 2'b00} - 64'(PC_STEP);
  assign k_b     = {{36{bus.IR[25]}}, bus.IR[25:0], 2'b00} - 64'(PC_STEP);

`ifdef LVCONTROL_BCOND_EN
  logic [3:0] flags;
  logic       set_flags;
  logic       cond_base;
  logic       cond_true;

  always_ff @(posedge clock) begin
    if (!reset) begin
      flags <= '0;
    end else if (state == S_EXEC && set_flags) begin
      flags <= bus.status;
    end
  end

  // flags = {N,Z,C,V}; odd codes invert the base test except AL/NV.
  always_comb begin
    cond_base = 1'b1;
    case (bus.IR[3:1])
      3'b000:  cond_base = flags[2];
      3'b001:  cond_base = flags[1];
      3'b010:  cond_base = flags[3];
      3'b011:  cond_base = flags[0];
      3'b100:  cond_base = flags[1] & ~flags[2];
      3'b101:  cond_base = (flags[3] == flags[0]);
      3'b110:  cond_base = ~flags[2] & (flags[3] == flags[0]);
      default: cond_base = 1'b1;
    endcase
    cond_true = (bus.IR[0] && bus.IR[3:1] != 3'b111) ? ~cond_base : cond_base;
  end
`else
  logic unused_status;
  assign unused_status = ^{bus.status[3], bus.status[1:0]};
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_RST;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    illegal        = 1'b0;
    bus.IL         = 1'b0;
    bus.SA         = '0;
    bus.SB         = '0;
    bus.DA         = '0;
    bus.W          = 1'b0;
    bus.FS         = '0;
    bus.C0         = 1'b0;
    bus.K          = '0;
    bus.B_sel      = 1'b0;
    bus.EN_B       = 1'b0;
    bus.EN_ALU     = 1'b0;
    bus.OUT_EN     = 1'b0;
    bus.WR_EN      = 1'b0;
    bus.EN_ADDR_PC = 1'b0;
    bus.PS         = 2'b00;
    bus.EN_PC      = 1'b0;
    bus.halted     = 1'b0;
`ifdef LVCONTROL_BCOND_EN
    set_flags      = 1'b0;
`endif

    case (state)
      S_RST: state_next = S_FETCH;

      S_FETCH: begin
        bus.EN_ADDR_PC = 1'b1;
        bus.OUT_EN     = 1'b1;
        if (bus.mem_ready) begin
          bus.IL     = 1'b1;
          bus.PS     = 2'b01;
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        // In the arithmetic arms opcode[7] separates the immediate form from register form.
        casez (opcode)
          11'b10001011000, 11'b1001000100?,
          11'b11001011000, 11'b1101000100?: begin
            bus.SA     = rn;
            bus.SB     = rm;
            bus.DA     = rd;
            bus.FS     = opcode[9] ? 5'b01001 : 5'b01000;
            bus.C0     = opcode[9];
            bus.B_sel  = opcode[7];
            bus.K      = opcode[7] ? k_imm12 : '0;
            bus.EN_ALU = 1'b1;
            bus.W      = 1'b1;
`ifdef LVCONTROL_BCOND_EN
            set_flags  = 1'b1;
`endif
          end
          11'b10001010000, 11'b10101010000: begin
            bus.SA     = rn;
            bus.SB     = rm;
            bus.DA     = rd;
            bus.FS     = opcode[8] ? 5'b00100 : 5'b00000;
            bus.EN_ALU = 1'b1;
            bus.W      = 1'b1;
          end
          11'b11111000010: begin
            bus.SA     = rn;
            bus.FS     = 5'b01000;
            bus.B_sel  = 1'b1;
            bus.K      = k_dt;
            bus.OUT_EN = 1'b1;
            bus.DA     = rd;
            bus.W      = 1'b1;
          end
          11'b11111000000: begin
            bus.SA     = rn;
            bus.FS     = 5'b01000;
            bus.B_sel  = 1'b1;
            bus.K      = k_dt;
            bus.SB     = rd;
            bus.EN_B   = 1'b1;
            bus.WR_EN  = 1'b1;
          end
          11'b1011010????: begin
            bus.SA = rd;
            bus.FS = 5'b10000;
            if (bus.status[2] ^ opcode[3]) begin
              bus.PS = 2'b10;
              bus.K  = k_cb;
            end
          end
          11'b000101?????: begin
            bus.PS = 2'b10;
            bus.K  = k_b;
          end
`ifdef LVCONTROL_BCOND_EN
          11'b01010100???: begin
            if (bus.IR[4]) begin
              illegal = 1'b1;
            end else if (cond_true) begin
              bus.PS = 2'b10;
              bus.K  = k_cb;
            end
          end
`endif
          default: illegal = 1'b1;
        endcase
        state_next = illegal ? S_HALT : S_FETCH;
      end

      S_HALT: bus.halted = 1'b1;

      default: state_next = S_RST;
    endcase
  end
endmodule

// File: tb/tb_lvcontrol_fsm.sv
// Scoreboard bench for lvcontrol_fsm: directed instructions with hand-computed control words.
module tb_lvcontrol_fsm;
  typedef struct packed {
    logic        IL;
    logic [4:0]  SA;
    logic [4:0]  SB;
    logic [4:0]  DA;
    logic        W;
    logic [4:0]  FS;
    logic        C0;
    logic [63:0] K;
    logic        B_sel;
    logic        EN_B;
    logic        EN_ALU;
    logic        OUT_EN;
    logic        WR_EN;
    logic        EN_ADDR_PC;
    logic [1:0]  PS;
    logic        EN_PC;
    logic        halted;
  } ctrl_t;

  typedef struct {
    string name;
    ctrl_t exp;
  } sb_item_t;

  logic     clk = 1'b0;
  logic     rst;
  int       n_checks = 0;
  int       n_fail = 0;
  sb_item_t sb[$];

  lvcontrol_fsm_if bus();

  lvcontrol_fsm #(.PC_STEP(4)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t c_fetch(input logic rdy);
    ctrl_t c = '0;
    c.EN_ADDR_PC = 1'b1;
    c.OUT_EN     = 1'b1;
    c.IL         = rdy;
    c.PS         = rdy ? 2'b01 : 2'b00;
    return c;
  endfunction

  function automatic ctrl_t c_halt();
    ctrl_t c = '0;
    c.halted = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t c_alu(input logic [4:0] sa, input logic [4:0] sbr, input logic [4:0] da,
                                  input logic [4:0] fs, input logic c0, input logic bsel,
                                  input logic [63:0] k);
    ctrl_t c = '0;
    c.SA = sa; c.SB = sbr; c.DA = da; c.FS = fs; c.C0 = c0; c.B_sel = bsel; c.K = k;
    c.EN_ALU = 1'b1;
    c.W      = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t c_br(input logic [4:0] sa, input logic [4:0] fs, input logic [1:0] ps,
                                 input logic [63:0] k);
    ctrl_t c = '0;
    c.SA = sa; c.FS = fs; c.PS = ps; c.K = k;
    return c;
  endfunction

  task automatic step(input logic r, input logic rdy, input logic [31:0] ir, input logic [3:0] st,
                      input string nm, input ctrl_t e);
    sb_item_t it;
    @(posedge clk);
    #1;
    rst           = r;
    bus.mem_ready = rdy;
    bus.IR        = ir;
    bus.status    = st;
    it.name = nm;
    it.exp  = e;
    sb.push_back(it);
  endtask

  task automatic instr(input string nm, input logic [31:0] ir, input logic [3:0] st, input ctrl_t e);
    step(1'b1, 1'b1, ir, 4'b0000, {nm, "_fetch"}, c_fetch(1'b1));
    step(1'b1, 1'b1, ir, st, nm, e);
  endtask

  // Monitor: every cycle the DUT presents a control word; compare it against the queue head.
  initial begin
    sb_item_t it;
    ctrl_t    act;
    forever begin
      @(negedge clk);
      act.IL = bus.IL; act.SA = bus.SA; act.SB = bus.SB; act.DA = bus.DA; act.W = bus.W;
      act.FS = bus.FS; act.C0 = bus.C0; act.K = bus.K; act.B_sel = bus.B_sel;
      act.EN_B = bus.EN_B; act.EN_ALU = bus.EN_ALU; act.OUT_EN = bus.OUT_EN;
      act.WR_EN = bus.WR_EN; act.EN_ADDR_PC = bus.EN_ADDR_PC; act.PS = bus.PS;
      act.EN_PC = bus.EN_PC; act.halted = bus.halted;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        n_checks++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
        n_checks++;
        if ($countones({act.EN_B, act.EN_ALU, act.OUT_EN, act.EN_PC}) > 1) begin
          n_fail++;
          $display("FAIL bus_excl(%s): drivers %b expected at most one set", it.name,
                   {act.EN_B, act.EN_ALU, act.OUT_EN, act.EN_PC});
        end
      end
    end
  end

  initial begin
    ctrl_t e;
    rst           = 1'b0;
    bus.IR        = '0;
    bus.status    = '0;
    bus.mem_ready = 1'b0;

    step(1'b0, 1'b0, 32'h0, 4'h0, "reset_low0", '0);
    step(1'b0, 1'b0, 32'h0, 4'h0, "reset_low1", '0);
    step(1'b1, 1'b0, 32'h0, 4'h0, "rst_state", '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 4'h0, "fetch_wait", c_fetch(1'b0));

    instr("addi", 32'h91001423, 4'b0000, c_alu(5'd1, 5'd0, 5'd3, 5'b01000, 1'b0, 1'b1, 64'd5));
    instr("cbz_taken", 32'hB4000062, 4'b0100, c_br(5'd2, 5'b10000, 2'b10, 64'd8));
    instr("cbz_not", 32'hB4000062, 4'b0000, c_br(5'd2, 5'b10000, 2'b00, 64'd0));

    e = '0; e.SA = 5'd5; e.FS = 5'b01000; e.B_sel = 1'b1; e.K = 64'hFFFF_FFFF_FFFF_FFF8;
    e.OUT_EN = 1'b1; e.DA = 5'd4; e.W = 1'b1;
    instr("ldur", 32'hF85F80A4, 4'b0000, e);

    e = '0; e.SA = 5'd7; e.FS = 5'b01000; e.B_sel = 1'b1; e.K = 64'd16;
    e.SB = 5'd6; e.EN_B = 1'b1; e.WR_EN = 1'b1;
    instr("stur", 32'hF80100E6, 4'b0000, e);

    instr("b_back", 32'h17FFFFFF, 4'b0000, c_br(5'd0, 5'd0, 2'b10, 64'hFFFF_FFFF_FFFF_FFF8));
    instr("cbnz_taken", 32'hB5FFFFE9, 4'b0000, c_br(5'd9, 5'b10000, 2'b10, 64'hFFFF_FFFF_FFFF_FFF8));
    instr("orr", 32'hAA030041, 4'b0000, c_alu(5'd2, 5'd3, 5'd1, 5'b00100, 1'b0, 1'b0, 64'd0));
    instr("sub", 32'hCB030041, 4'b0100, c_alu(5'd2, 5'd3, 5'd1, 5'b01001, 1'b1, 1'b0, 64'd0));

`ifdef LVCONTROL_BCOND_EN
    instr("beq_taken", 32'h54000040, 4'b0000, c_br(5'd0, 5'd0, 2'b10, 64'd4));
    instr("bne_not", 32'h54000041, 4'b0000, '0);
    instr("illegal", 32'hFFFFFFFF, 4'b0000, '0);
`else
    instr("beq_undef", 32'h54000040, 4'b0000, '0);
`endif

    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'hFFFFFFFF, 4'b0101, "halt_hold", c_halt());
    step(1'b0, 1'b0, 32'h0, 4'h0, "halt_rst_req", c_halt());
    step(1'b0, 1'b0, 32'h0, 4'h0, "halt_to_rst", '0);
    step(1'b1, 1'b0, 32'h0, 4'h0, "rst_again", '0);
    step(1'b1, 1'b0, 32'h0, 4'h0, "fetch_again", c_fetch(1'b0));

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
